lzc_pipe: RTL and testbench
===========================

// Module: lzc_pipe
// PURPOSE
//  Parametrised, pipelined leading-zero/leading-one counter with normaliser. Successor to the
//  fixed-width combinational 3-bit lz tree, adding generic width, a selectable count mode and
//  registered stages with a valid/ready handshake. Sits in front of float pack/normalise logic:
//  it gives the shift amount, the normalised mantissa and an all-equal flag.
// PARAMETERS
//  WIDTH    32                   data width in bits, >= 2
//  STAGES   2                    register stages from input to output, 1..$clog2(WIDTH)+1
//  COUNT_W  $clog2(WIDTH+1)      count width, derived; callers never override it
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input word valid
//  in_ready   out  1        block accepts a word this cycle
//  in_data    in   WIDTH    word to scan from the MSB down
//  in_mode    in   1        0: count leading zeros, 1: count leading ones
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts the result
//  out_count  out  COUNT_W  number of leading bits equal to mode, 0..WIDTH
//  out_all    out  1        1 when every bit equals the mode (out_count == WIDTH)
//  out_norm   out  WIDTH    in_data << out_count, zero-filled; all zeros when out_all
// BEHAVIOUR
//  - Reset (rst_n low, async): every stage valid bit and data register clears. out_valid=0,
//    out_count=0, out_all=0, out_norm=0. in_ready=1 from the first edge after release.
//  - Global advance: adv = out_ready | ~out_valid. in_ready = adv. All stages shift together on adv.
//    When adv=0, every stage holds. Bubbles are not squeezed out.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Latency: exactly STAGES cycles from an input transfer to out_valid, with no stall.
//    Throughput is one word per cycle while out_ready=1.
//  - Count tree: invert the data when in_mode=1, then append one pad bit of 1 at the LSB side so the
//    all-equal case folds into the tree. Do a log2 tree reduction. Each node gives
//    {both_halves_zero, count} = {hi_z & lo_z, hi_z ? {1,lo_cnt} : {0,hi_cnt}}.
//    Tree levels are split evenly across STAGES-1 internal registers. The last stage registers
//    the outputs.
//  - out_norm: barrel shift left by the count, done in the final stage. Shift amount WIDTH yields 0.
//  - in_mode travels with its word. Mixing modes on consecutive words is legal.
//  - Stall with data held: out_count, out_all, out_norm and out_valid stay stable until out_ready.
//  - Simultaneous transfer in and out while full: both happen. No word is lost or duplicated.
//  - Reset mid-operation: all words in flight are dropped. No out_valid pulse after reset releases
//    until a new input is accepted.
//  - in_data is ignored when in_valid=0, and the stage valid bit stays 0.
// TESTING
//  1 WIDTH=32,STAGES=2: in 0x0001_0000 mode0 -> 2 cycles later out_count=15, out_all=0,
//    out_norm=0x8000_0000
//  2 in 0x0000_0000 mode0 -> out_count=32, out_all=1, out_norm=0. in 0xFFFF_FFFF mode1 ->
//    out_count=32, out_all=1
//  3 in 0xF0F0_0000 mode1 -> out_count=4, out_norm=0x0F00_0000. in 0x8000_0000 mode0 -> out_count=0,
//    out_norm unchanged
//  4 stream 8 words with out_ready low on cycles 3-5 -> in_ready low on the same cycles, outputs held,
//    all 8 results in order, none dropped
//  5 assert rst_n=0 with 2 words in flight -> out_valid=0 and all outputs 0 immediately. No stale
//    result after release
//  6 random sweep at WIDTH=3,STAGES=1 and WIDTH=53,STAGES=4, both modes, random out_ready ->
//    results match the reference model

Source files
------------

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero/leading-one counter with normaliser.
// Count tree registers are spread over STAGES-1 level boundaries; the final stage shifts and registers the outputs.
module lzc_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned COUNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_all,
  output logic [WIDTH-1:0]   out_norm
);

  localparam int unsigned LEVELS = COUNT_W;
  localparam int unsigned LEAVES = 1 << LEVELS;
  localparam int unsigned DIV    = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic [LEVELS:0] boundaries();
    logic [LEVELS:0] b;
    b = '0;
    for (int unsigned j = 1; j < STAGES; j++) b[(j * LEVELS) / DIV] = 1'b1;
    return b;
  endfunction

  localparam logic [LEVELS:0] BND = boundaries();

  logic              adv;
  logic              ready_en;
  logic              take;
  logic [LEAVES-1:0] pad;
  logic [WIDTH-1:0]  norm;

  logic [LEAVES-1:0]  z_comb [LEVELS+1];
  logic [LEAVES-1:0]  z_out  [LEVELS+1];
  logic [LEAVES-1:0]  z_reg  [LEVELS+1];
  logic [COUNT_W-1:0] c_comb [LEVELS+1][LEAVES];
  logic [COUNT_W-1:0] c_out  [LEVELS+1][LEAVES];
  logic [COUNT_W-1:0] c_reg  [LEVELS+1][LEAVES];
  logic [WIDTH-1:0]   d_in   [LEVELS+1];
  logic [WIDTH-1:0]   d_out  [LEVELS+1];
  logic [WIDTH-1:0]   d_reg  [LEVELS+1];
  logic               v_in   [LEVELS+1];
  logic               v_out  [LEVELS+1];
  logic               v_reg  [LEVELS+1];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv & ready_en;
  assign take     = in_valid & in_ready;

  // Level l node i covers pad[i*2^l +: 2^l]; z flags an all-zero node, count is its leading-zero count.
  // The pad 1 below the data guarantees a non-zero root whose count is 0..WIDTH.
  always_comb begin
    pad = '0;
    pad[LEAVES-1 -: WIDTH] = in_mode ? ~in_data : in_data;
    pad[LEAVES-1-WIDTH] = 1'b1;
    for (int unsigned l = 0; l <= LEVELS; l++) begin
      z_comb[l] = '0;
      z_out[l]  = '0;
      d_in[l]   = '0;
      d_out[l]  = '0;
      v_in[l]   = 1'b0;
      v_out[l]  = 1'b0;
      for (int unsigned i = 0; i < LEAVES; i++) begin
        c_comb[l][i] = '0;
        c_out[l][i]  = '0;
      end
    end
    for (int unsigned l = 0; l <= LEVELS; l++) begin
      if (l == 0) begin
        z_comb[0] = ~pad;
        d_in[0]   = in_data;
        v_in[0]   = take;
      end else begin
        d_in[l] = d_out[l-1];
        v_in[l] = v_out[l-1];
        for (int unsigned i = 0; i < LEAVES / 2; i++) begin
          if (i < (LEAVES >> l)) begin
            z_comb[l][i] = z_out[l-1][2*i+1] & z_out[l-1][2*i];
            if (z_out[l-1][2*i+1]) begin
              c_comb[l][i]      = c_out[l-1][2*i];
              c_comb[l][i][l-1] = 1'b1;
            end else begin
              c_comb[l][i] = c_out[l-1][2*i+1];
            end
          end
        end
      end
      z_out[l] = BND[l] ? z_reg[l] : z_comb[l];
      d_out[l] = BND[l] ? d_reg[l] : d_in[l];
      v_out[l] = BND[l] ? v_reg[l] : v_in[l];
      for (int unsigned i = 0; i < LEAVES; i++)
        c_out[l][i] = BND[l] ? c_reg[l][i] : c_comb[l][i];
    end
    norm = d_out[LEVELS] << c_out[LEVELS][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_all   <= 1'b0;
      out_norm  <= '0;
      for (int unsigned l = 0; l <= LEVELS; l++) begin
        z_reg[l] <= '0;
        d_reg[l] <= '0;
        v_reg[l] <= 1'b0;
        for (int unsigned i = 0; i < LEAVES; i++) c_reg[l][i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (adv) begin
        for (int unsigned l = 0; l <= LEVELS; l++) begin
          if (BND[l]) begin
            v_reg[l] <= v_in[l];
            if (v_in[l]) begin
              z_reg[l] <= z_comb[l];
              d_reg[l] <= d_in[l];
              for (int unsigned i = 0; i < LEAVES; i++) c_reg[l][i] <= c_comb[l][i];
            end
          end
        end
        out_valid <= v_out[LEVELS];
        if (v_out[LEVELS]) begin
          out_count <= c_out[LEVELS][0];
          out_all   <= (c_out[LEVELS][0] == COUNT_W'(WIDTH));
          out_norm  <= norm;
        end
      end
    end
  end

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed and randomised checks of lzc_pipe at (32,2), (3,1) and (53,4).
module tb_lzc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int checks = 0;
  int errors = 0;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_all;
  logic [31:0] a_in_data, a_out_norm;
  logic [5:0]  a_out_count;

  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_all;
  logic [2:0]  b_in_data, b_out_norm;
  logic [1:0]  b_out_count;

  logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_all;
  logic [52:0] c_in_data, c_out_norm;
  logic [5:0]  c_out_count;

  lzc_pipe #(.WIDTH(32), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_all(a_out_all), .out_norm(a_out_norm));

  lzc_pipe #(.WIDTH(3), .STAGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_all(b_out_all), .out_norm(b_out_norm));

  lzc_pipe #(.WIDTH(53), .STAGES(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_count(c_out_count), .out_all(c_out_all), .out_norm(c_out_norm));

  // Hand-computed vectors: data, mode, count, all, norm.
  logic [31:0] v_data [10] = '{32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF0F0_0000,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF,
                              32'hFFFF_FFFE, 32'h00FF_0000};
  logic        v_mode [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [5:0]  v_cnt  [10] = '{6'd15, 6'd32, 6'd32, 6'd4, 6'd0, 6'd0, 6'd31, 6'd0, 6'd31, 6'd8};
  logic        v_all  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_norm [10] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0F00_0000,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'h0000_0000, 32'hFF00_0000};

  function automatic int unsigned ref_cnt(logic [63:0] d, logic m, int unsigned w);
    int unsigned n = 0;
    bit run = 1'b1;
    for (int unsigned i = 0; i < w; i++) begin
      if (run && d[w-1-i] == m) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [63:0] ref_norm(logic [63:0] d, int unsigned n, int unsigned w);
    logic [63:0] r;
    r = (n >= w) ? 64'd0 : (d << n);
    return r & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_mode = 0; c_in_data = '0; c_out_ready = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_all, a_out_count, a_out_norm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b all=%0b count=%0d norm=%h, want all zero",
               a_out_valid, a_out_all, a_out_count, a_out_norm);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_vectors();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_data = v_data[k]; a_in_mode = v_mode[k]; a_out_ready = 1;
      @(negedge clk);
      a_in_valid = 0; a_in_data = 32'hDEAD_BEEF;
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d early_valid: got %b want 0", k, a_out_valid);
      end
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_count !== v_cnt[k] || a_out_all !== v_all[k] ||
          a_out_norm !== v_norm[k]) begin
        errors++;
        $display("FAIL vec%0d result: valid=%b count=%0d all=%b norm=%h, want 1 %0d %b %h",
                 k, a_out_valid, a_out_count, a_out_all, a_out_norm, v_cnt[k], v_all[k], v_norm[k]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcv = 0;
    logic [5:0]  hold_cnt;
    logic [31:0] hold_norm;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 3 && cyc <= 5);
      a_in_valid  = (sent < 8);
      a_in_data   = (sent < 8) ? v_data[sent] : 32'h0;
      a_in_mode   = (sent < 8) ? v_mode[sent] : 1'b0;
      #1;
      checks++;
      if (a_in_ready !== !(cyc >= 3 && cyc <= 5)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, a_in_ready, !(cyc >= 3 && cyc <= 5));
      end
      if (cyc == 3) begin
        hold_cnt = a_out_count; hold_norm = a_out_norm;
      end
      if (cyc == 4 || cyc == 5) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_count !== hold_cnt || a_out_norm !== hold_norm) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d: valid=%b count=%0d norm=%h, want 1 %0d %h",
                   cyc, a_out_valid, a_out_count, a_out_norm, hold_cnt, hold_norm);
        end
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_count !== v_cnt[rcv] || a_out_all !== v_all[rcv] || a_out_norm !== v_norm[rcv]) begin
          errors++;
          $display("FAIL b2b_word%0d: count=%0d all=%b norm=%h, want %0d %b %h",
                   rcv, a_out_count, a_out_all, a_out_norm, v_cnt[rcv], v_all[rcv], v_norm[rcv]);
        end
        rcv++;
      end
      if (a_in_valid && a_in_ready) sent++;
    end
    checks++;
    if (rcv != 8) begin
      errors++;
      $display("FAIL b2b_received: got %0d want 8", rcv);
    end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    a_in_valid = 1; a_in_data = v_data[3]; a_in_mode = v_mode[3]; a_out_ready = 1;
    @(negedge clk);
    a_in_data = v_data[6]; a_in_mode = v_mode[6];
    @(negedge clk);
    a_in_valid = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_out_all, a_out_count, a_out_norm} !== '0) begin
      errors++;
      $display("FAIL flight_reset: valid=%b all=%b count=%0d norm=%h, want all zero",
               a_out_valid, a_out_all, a_out_count, a_out_norm);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flight_stale cyc%0d: out_valid=%b want 0", cyc, a_out_valid);
      end
    end
    a_in_valid = 1; a_in_data = v_data[9]; a_in_mode = v_mode[9];
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_count !== v_cnt[9] || a_out_norm !== v_norm[9]) begin
      errors++;
      $display("FAIL flight_recover: valid=%b count=%0d norm=%h, want 1 %0d %h",
               a_out_valid, a_out_count, a_out_norm, v_cnt[9], v_norm[9]);
    end
  endtask

  task automatic test_sweep();
    int unsigned qb_cnt[$];
    logic [2:0]  qb_norm[$];
    int unsigned qc_cnt[$];
    logic [52:0] qc_norm[$];
    int unsigned ec;
    logic [63:0] en;
    logic [63:0] r;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(negedge clk);
      if (cyc < 400) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_in_mode  = 1'($urandom_range(0, 1));
        b_in_data  = 3'($urandom);
        b_out_ready = ($urandom_range(0, 3) != 0);
        c_in_valid = 1'($urandom_range(0, 1));
        c_in_mode  = 1'($urandom_range(0, 1));
        r = {$urandom, $urandom};
        r = r >> $urandom_range(0, 56);
        c_in_data  = c_in_mode ? ~r[52:0] : r[52:0];
        c_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        b_in_valid = 0; b_out_ready = 1;
        c_in_valid = 0; c_out_ready = 1;
      end
      #1;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (qb_cnt.size() == 0) begin
          errors++;
          $display("FAIL sweep_b_extra: unexpected result count=%0d", b_out_count);
        end else begin
          ec = qb_cnt.pop_front();
          en = 64'(qb_norm.pop_front());
          if (b_out_count !== 2'(ec) || b_out_all !== (ec == 3) || b_out_norm !== en[2:0]) begin
            errors++;
            $display("FAIL sweep_b: count=%0d all=%b norm=%b, want %0d %b %b",
                     b_out_count, b_out_all, b_out_norm, ec, ec == 3, en[2:0]);
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        ec = ref_cnt(64'(b_in_data), b_in_mode, 3);
        en = ref_norm(64'(b_in_data), ec, 3);
        qb_cnt.push_back(ec);
        qb_norm.push_back(en[2:0]);
      end
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (qc_cnt.size() == 0) begin
          errors++;
          $display("FAIL sweep_c_extra: unexpected result count=%0d", c_out_count);
        end else begin
          ec = qc_cnt.pop_front();
          en = 64'(qc_norm.pop_front());
          if (c_out_count !== 6'(ec) || c_out_all !== (ec == 53) || c_out_norm !== en[52:0]) begin
            errors++;
            $display("FAIL sweep_c: count=%0d all=%b norm=%h, want %0d %b %h",
                     c_out_count, c_out_all, c_out_norm, ec, ec == 53, en[52:0]);
          end
        end
      end
      if (c_in_valid && c_in_ready) begin
        ec = ref_cnt(64'(c_in_data), c_in_mode, 53);
        en = ref_norm(64'(c_in_data), ec, 53);
        qc_cnt.push_back(ec);
        qc_norm.push_back(en[52:0]);
      end
    end
    checks++;
    if (qb_cnt.size() != 0 || qc_cnt.size() != 0) begin
      errors++;
      $display("FAIL sweep_drain: pending b=%0d c=%0d, want 0 0", qb_cnt.size(), qc_cnt.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_in_flight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
